// File: rtl/lpc_reg_arbiter_if.sv
// lpc_reg_arbiter_if: bus bundle between the LPC decoder (host), the on-board
// secondary master, and the register block / read mux.
//   Host side      : HostWr, HostRd, HostAddr, HostData
//   Secondary side : SecReq, SecWe, SecAddr, SecWData -> SecAck, SecErr, SecRData, SecBusy
//   Register side  : RegWr, RegRd, RegAddr, RegData -> RegRdData
// Modports: slave = arbiter view, master = environment (decoder/secondary/reg block) view.
interface lpc_reg_arbiter_if;
   localparam int unsigned DW = 8;

   logic          HostWr;
   logic          HostRd;
   logic [DW-1:0] HostAddr;
   logic [DW-1:0] HostData;
   logic          SecReq;
   logic          SecWe;
   logic [DW-1:0] SecAddr;
   logic [DW-1:0] SecWData;
   logic [DW-1:0] RegRdData;
   logic          RegWr;
   logic          RegRd;
   logic [DW-1:0] RegAddr;
   logic [DW-1:0] RegData;
   logic          SecAck;
   logic          SecErr;
   logic [DW-1:0] SecRData;
   logic          SecBusy;

   modport slave (
      input  HostWr, HostRd, HostAddr, HostData,
      input  SecReq, SecWe, SecAddr, SecWData,
      input  RegRdData,
      output RegWr, RegRd, RegAddr, RegData,
      output SecAck, SecErr, SecRData, SecBusy
   );

   modport master (
      output HostWr, HostRd, HostAddr, HostData,
      output SecReq, SecWe, SecAddr, SecWData,
      output RegRdData,
      input  RegWr, RegRd, RegAddr, RegData,
      input  SecAck, SecErr, SecRData, SecBusy
   );
endinterface

// File: rtl/lpc_reg_arbiter.sv
// lpc_reg_arbiter: shares the LPC register-file port between the LPC decoder
// (absolute priority, fixed timing) and a secondary req/ack master.
// Ports:
//   LpcClock  - 33 MHz LPC clock, only clock
//   PciReset  - asynchronous active-high reset
//   bus       - lpc_reg_arbiter_if.slave (host strobes, secondary handshake,
//               registered register-block strobes and read-data return)
// Parameters:
//   RD_LAT  - cycles from RegRd to valid RegRdData (1..3)
//   SEC_TMO - max host-deferred cycles before a secondary request errors (4..255)
// Optional build macro LPC_ARB_PROT_EN: when defined, secondary writes to
// 8'h00..8'h0F are rejected with SecErr; reads of that range stay legal.
module lpc_reg_arbiter #(
   parameter int unsigned RD_LAT  = 1,
   parameter int unsigned SEC_TMO = 64
) (
   input  logic             LpcClock,
   input  logic             PciReset,
   lpc_reg_arbiter_if.slave bus
);
   localparam int unsigned DW    = 8;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned LAT_W = 2;
   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(SEC_TMO);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_ACK,
      ST_ERR
   } state_t;

   state_t             r_state,     w_state_nxt;
   logic [CNT_W-1:0]   r_tmo_cnt,   w_tmo_nxt;
   logic [LAT_W-1:0]   r_lat_cnt,   w_lat_nxt;
   logic               r_abort,     w_abort_nxt;
   logic               r_we;
   logic [DW-1:0]      r_addr;
   logic [DW-1:0]      r_wdata;
   logic               r_reg_wr,    w_reg_wr_nxt;
   logic               r_reg_rd,    w_reg_rd_nxt;
   logic [DW-1:0]      r_reg_addr,  w_reg_addr_nxt;
   logic [DW-1:0]      r_reg_data,  w_reg_data_nxt;
   logic               r_sec_ack,   w_sec_ack_nxt;
   logic               r_sec_err,   w_sec_err_nxt;
   logic [DW-1:0]      r_sec_rdata;
   logic               r_sec_busy,  w_sec_busy_nxt;
   logic               w_latch;
   logic               w_capture;
   logic               w_host_any;
   logic               w_prot;
   logic [CNT_W-1:0]   w_tmo_inc;

   // Protected-range comparator only exists when the feature is built in
`ifdef LPC_ARB_PROT_EN
   assign w_prot = r_we & (r_addr[7:4] == 4'h0);
`else
   assign w_prot = 1'b0;
`endif

   assign w_host_any = bus.HostWr | bus.HostRd;
   assign w_tmo_inc  = (r_tmo_cnt == {CNT_W{1'b1}}) ? r_tmo_cnt : r_tmo_cnt + CNT_W'(1);

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt    = r_state;
      w_tmo_nxt      = r_tmo_cnt;
      w_lat_nxt      = r_lat_cnt;
      w_abort_nxt    = r_abort;
      w_latch        = 1'b0;
      w_capture      = 1'b0;
      // Host strobes are always forwarded; address/data hold otherwise
      w_reg_wr_nxt   = bus.HostWr;
      w_reg_rd_nxt   = bus.HostRd & ~bus.HostWr;
      w_reg_addr_nxt = w_host_any ? bus.HostAddr : r_reg_addr;
      w_reg_data_nxt = bus.HostWr ? bus.HostData : r_reg_data;

      unique case (r_state)
         ST_IDLE: begin
            w_tmo_nxt   = '0;
            w_abort_nxt = 1'b0;
            if (bus.SecReq) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!bus.SecReq) begin
               w_state_nxt = ST_IDLE;
            end else if (w_prot) begin
               w_state_nxt = ST_ERR;
            end else if (w_host_any) begin
               // Deferred by host traffic this cycle
               w_tmo_nxt = w_tmo_inc;
               if (w_tmo_inc >= TMO_LIMIT) w_state_nxt = ST_ERR;
            end else begin
               w_reg_wr_nxt   = r_we;
               w_reg_rd_nxt   = ~r_we;
               w_reg_addr_nxt = r_addr;
               if (r_we) begin
                  w_reg_data_nxt = r_wdata;
                  w_state_nxt    = ST_ACK;
               end else begin
                  w_lat_nxt   = LAT_W'(RD_LAT);
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!bus.SecReq) w_abort_nxt = 1'b1;
            if (r_lat_cnt == '0) begin
               // Read data is valid this cycle; an aborted read ends silently
               if (r_abort || !bus.SecReq) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = ST_ACK;
               end
            end else begin
               w_lat_nxt = r_lat_cnt - LAT_W'(1);
            end
         end
         ST_ACK:  w_state_nxt = ST_IDLE;
         ST_ERR:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase

      // Handshake outputs are registered from the upcoming state
      w_sec_ack_nxt  = (w_state_nxt == ST_ACK);
      w_sec_err_nxt  = (w_state_nxt == ST_ERR);
      w_sec_busy_nxt = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT);
   end

   // State, request latch and registered outputs
   always_ff @(posedge LpcClock or posedge PciReset) begin
      if (PciReset) begin
         r_state     <= ST_IDLE;
         r_tmo_cnt   <= '0;
         r_lat_cnt   <= '0;
         r_abort     <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_reg_wr    <= 1'b0;
         r_reg_rd    <= 1'b0;
         r_reg_addr  <= '0;
         r_reg_data  <= '0;
         r_sec_ack   <= 1'b0;
         r_sec_err   <= 1'b0;
         r_sec_rdata <= '0;
         r_sec_busy  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tmo_cnt   <= w_tmo_nxt;
         r_lat_cnt   <= w_lat_nxt;
         r_abort     <= w_abort_nxt;
         r_reg_wr    <= w_reg_wr_nxt;
         r_reg_rd    <= w_reg_rd_nxt;
         r_reg_addr  <= w_reg_addr_nxt;
         r_reg_data  <= w_reg_data_nxt;
         r_sec_ack   <= w_sec_ack_nxt;
         r_sec_err   <= w_sec_err_nxt;
         r_sec_busy  <= w_sec_busy_nxt;
         if (w_latch) begin
            r_we    <= bus.SecWe;
            r_addr  <= bus.SecAddr;
            r_wdata <= bus.SecWData;
         end
         if (w_capture) r_sec_rdata <= bus.RegRdData;
      end
   end

   assign bus.RegWr    = r_reg_wr;
   assign bus.RegRd    = r_reg_rd;
   assign bus.RegAddr  = r_reg_addr;
   assign bus.RegData  = r_reg_data;
   assign bus.SecAck   = r_sec_ack;
   assign bus.SecErr   = r_sec_err;
   assign bus.SecRData = r_sec_rdata;
   assign bus.SecBusy  = r_sec_busy;
endmodule
